// File: rtl/soc_gate_en_ctrl.sv
// Enable-qualifier controller for a downstream non-clock AND2 gate.
// Synchronizes an asynchronous enable request, applies a wake hold-off before
// asserting en_o and a busy-aware drain hold-off before releasing it.
// en_o and en_ack are dedicated flops so they cannot glitch.

module soc_gate_en_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             en_req_async,
  input  logic [CNT_W-1:0] dly_on,
  input  logic [CNT_W-1:0] dly_off,
  input  logic             busy_in,
  output logic             en_o,
  output logic             en_ack,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    StOff   = 2'b00,
    StWake  = 2'b01,
    StOn    = 2'b10,
    StDrain = 2'b11
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   en_q, en_d;
  logic                   ack_q, ack_d;
  logic                   cnt_zero;

  // Request synchronizer; the only place en_req_async is sampled.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], en_req_async};
    end
  end

  assign req_s    = sync_q[SYNC_STAGES-1];
  assign cnt_zero = (cnt_q == '0);

  // State and hold-off counter registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= StOff;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic; delays are only sampled on their load cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StOff: begin
        if (req_s) begin
          state_d = StWake;
          cnt_d   = dly_on;
        end
      end
      StWake: begin
        if (!req_s) begin
          state_d = StOff;
        end else if (cnt_zero) begin
          state_d = StOn;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StOn: begin
        if (!req_s) begin
          state_d = StDrain;
          cnt_d   = dly_off;
        end
      end
      StDrain: begin
        // Re-request wins over drain; busy freezes the count without reload.
        if (req_s) begin
          state_d = StOn;
        end else if (!busy_in) begin
          if (cnt_zero) begin
            state_d = StOff;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = StOff;
      end
    endcase
  end

  // Output next values decoded from next state, so the flops track the state.
  always_comb begin
    en_d  = (state_d == StOn) || (state_d == StDrain);
    ack_d = (state_d == StOn);
  end

  // Dedicated output flops; reset clears them without waiting for a clock.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      en_q  <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      en_q  <= en_d;
      ack_q <= ack_d;
    end
  end

  assign en_o    = en_q;
  assign en_ack  = ack_q;
  assign state_o = state_q;

endmodule
